// File: rtl/fft_mem_sequencer.sv
// fft_mem_sequencer: loads N samples at bit-reversed addresses, then walks log2(N) radix-2 DIT stages of reads.
// Define FFT_NATURAL_ORDER_EN to write samples at natural (arrival-order) addresses instead.
module fft_mem_sequencer #(
    parameter int bit_width = 29,
    parameter int N = 16,
    parameter int SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [bit_width-1:0] Re_in,
    input  logic [bit_width-1:0] Im_in,
    output logic                 load_data,
    output logic [SIZE-1:0]      invert_adr,
    output logic [bit_width-1:0] Re_o,
    output logic [bit_width-1:0] Im_o,
    output logic                 en_rd,
    output logic [SIZE-1:0]      rd_ptr,
    output logic [6:0]           rd_angle_ptr,
    output logic [2:0]           stage,
    input  logic                 stage_ack,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [2:0] {IDLE, LOAD, READ, WAIT, FIN} state_t;
    state_t state, state_n;
    logic [SIZE-1:0] wr_cnt, rd_cnt, wr_adr, b, j, g, ptr;
    logic [7:0] jw;
    logic [6:0] angle;
    logic [2:0] s;
    logic accept;

    if (N != 2 ** SIZE || SIZE > 8 || SIZE < 2) begin : g_chk
        $fatal(1, "fft_mem_sequencer: N must equal 2**SIZE with 2 <= SIZE <= 8");
    end

`ifdef FFT_NATURAL_ORDER_EN
    assign wr_adr = wr_cnt;
`else
    for (genvar i = 0; i < SIZE; i++) begin : g_rev
        assign wr_adr[i] = wr_cnt[SIZE-1-i];
    end
`endif

    assign accept = (state == LOAD) && in_valid;

    // rd_cnt = 2*butterfly + half; top/bottom legs sit 2^s apart inside groups of 2^(s+1)
    always_comb begin
        b = rd_cnt >> 1;
        j = b & ((SIZE'(1) << s) - SIZE'(1));
        g = b >> s;
        ptr = (g << s << 1) | j | (SIZE'(rd_cnt[0]) << s);
        jw = 8'(j);
        angle = 7'(jw << (3'd7 - s));
    end

    always_comb begin
        state_n = state;
        in_ready = 1'b0;
        busy = 1'b1;
        done = 1'b0;
        stage = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                state_n = start ? LOAD : IDLE;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && wr_cnt == SIZE'(N - 1)) state_n = READ;
            end
            READ: begin
                stage = s;
                if (rd_cnt == SIZE'(N - 1)) state_n = WAIT;
            end
            WAIT: begin
                stage = s;
                if (stage_ack) state_n = (s == 3'(SIZE - 1)) ? FIN : READ;
            end
            FIN: begin
                done = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // counters wrap to 0 at N, so each stage and frame starts from zero without explicit clears
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wr_cnt <= '0;
            rd_cnt <= '0;
            s <= '0;
            load_data <= 1'b0;
            invert_adr <= '0;
            Re_o <= '0;
            Im_o <= '0;
            en_rd <= 1'b0;
            rd_ptr <= '0;
            rd_angle_ptr <= '0;
        end else begin
            state <= state_n;
            load_data <= accept;
            en_rd <= (state == READ);
            if (accept) begin
                invert_adr <= wr_adr;
                Re_o <= Re_in;
                Im_o <= Im_in;
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (state == READ) begin
                rd_ptr <= ptr;
                rd_angle_ptr <= angle;
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (state == WAIT && state_n == READ) s <= s + 3'd1;
            if (state == FIN) s <= '0;
        end
    end
endmodule

// File: tb/tb_fft_mem_sequencer.sv
// tb_fft_mem_sequencer: scoreboard bench for the N=16 sequencer; expected writes/reads queued, monitor compares.
module tb_fft_mem_sequencer;
    logic clk, rst, start, in_valid, in_ready, load_data, en_rd, stage_ack, busy, done;
    logic [28:0] Re_in, Im_in, Re_o, Im_o;
    logic [3:0] invert_adr, rd_ptr;
    logic [6:0] rd_angle_ptr;
    logic [2:0] stage;

    typedef struct {logic [31:0] adr, re, im;} wr_t;
    typedef struct {logic [31:0] ptr, ang, stg;} rd_t;
    wr_t wr_q[$];
    rd_t rd_q[$];
    int total = 0, passed = 0, done_cnt = 0, wr_seen = 0;

`ifdef FFT_NATURAL_ORDER_EN
    int adr_tab[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`else
    int adr_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`endif
    int rp[4][16] = '{
        '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
        '{0, 2, 1, 3, 4, 6, 5, 7, 8, 10, 9, 11, 12, 14, 13, 15},
        '{0, 4, 1, 5, 2, 6, 3, 7, 8, 12, 9, 13, 10, 14, 11, 15},
        '{0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15}};
    int ang[4][16] = '{
        '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 64, 64, 0, 0, 64, 64, 0, 0, 64, 64, 0, 0, 64, 64},
        '{0, 0, 32, 32, 64, 64, 96, 96, 0, 0, 32, 32, 64, 64, 96, 96},
        '{0, 0, 16, 16, 32, 32, 48, 48, 64, 64, 80, 80, 96, 96, 112, 112}};

    fft_mem_sequencer #(.bit_width(29), .N(16), .SIZE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .Re_in(Re_in), .Im_in(Im_in), .load_data(load_data), .invert_adr(invert_adr),
        .Re_o(Re_o), .Im_o(Im_o), .en_rd(en_rd), .rd_ptr(rd_ptr), .rd_angle_ptr(rd_angle_ptr),
        .stage(stage), .stage_ack(stage_ack), .busy(busy), .done(done));

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    function automatic void fail(string nm);
        total++;
        $display("FAIL %s: got no matching event expected one", nm);
    endfunction

    function automatic logic [28:0] imv(int i);
        return 29'(i * 7 + 100000);
    endfunction

    always @(negedge clk) begin : mon
        wr_t we;
        rd_t re;
        if (load_data) begin
            wr_seen++;
            if (wr_q.size() == 0) fail("wr_unexpected");
            else begin
                we = wr_q.pop_front();
                check("invert_adr", 32'(invert_adr), we.adr);
                check("Re_o", 32'(Re_o), we.re);
                check("Im_o", 32'(Im_o), we.im);
            end
        end
        if (en_rd) begin
            if (rd_q.size() == 0) fail("rd_unexpected");
            else begin
                re = rd_q.pop_front();
                check("rd_ptr", 32'(rd_ptr), re.ptr);
                check("rd_angle_ptr", 32'(rd_angle_ptr), re.ang);
                check("stage_rd", 32'(stage), re.stg);
            end
        end
        if (done) done_cnt++;
    end

    task automatic push_rd(input int k);
        for (int i = 0; i < 16; i++) rd_q.push_back('{32'(rp[k][i]), 32'(ang[k][i]), 32'(k)});
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_load_data"}, 32'(load_data), 0);
        check({tag, "_invert_adr"}, 32'(invert_adr), 0);
        check({tag, "_Re_o"}, 32'(Re_o), 0);
        check({tag, "_Im_o"}, 32'(Im_o), 0);
        check({tag, "_en_rd"}, 32'(en_rd), 0);
        check({tag, "_rd_ptr"}, 32'(rd_ptr), 0);
        check({tag, "_rd_angle_ptr"}, 32'(rd_angle_ptr), 0);
        check({tag, "_stage"}, 32'(stage), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    task automatic wait_en(input logic v, input string nm);
        int t = 0;
        while (en_rd !== v && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (en_rd !== v) fail(nm);
    endtask

    task automatic pulse_ack();
        @(posedge clk);
        #1 stage_ack = 1;
        @(posedge clk);
        #1 stage_ack = 0;
    endtask

    task automatic run_frame(input bit gap, input bit abort);
        int d0, w0, t;
        bit ok;
        d0 = done_cnt;
        w0 = wr_seen;
        push_rd(0);
        @(posedge clk);
        #1 start = 1;
        @(posedge clk);
        #1 start = 0;
        for (int i = 0; i < 16; i++) begin
            wr_q.push_back('{32'(adr_tab[i]), 32'(i), 32'(imv(i))});
            in_valid = 1;
            Re_in = 29'(i);
            Im_in = imv(i);
            @(negedge clk);
            t = 0;
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) fail("in_ready_timeout");
            @(posedge clk);
            #1;
            if (gap) begin
                in_valid = 0;
                Re_in = '1;
                Im_in = '1;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 0;
        @(negedge clk);
        check("in_ready_after_load", 32'(in_ready), 0);
        check("busy_after_load", 32'(busy), 1);
        for (int k = 0; k < 4; k++) begin
            wait_en(1, "en_rd_rise");
            if (k == 1) pulse_ack();
            if (abort && k == 2) begin
                repeat (3) @(negedge clk);
                @(posedge clk);
                #1 rst = 1;
                @(posedge clk);
                #1 rst = 0;
                rd_q.delete();
                @(negedge clk);
                check_idle("abort");
                repeat (5) @(negedge clk);
                check("abort_no_done", 32'(done_cnt - d0), 0);
                check("abort_wr_q_empty", 32'(wr_q.size()), 0);
                return;
            end
            wait_en(0, "en_rd_fall");
            if (k == 0) begin
                ok = 1;
                start = 1;
                repeat (20) begin
                    @(negedge clk);
                    ok &= (en_rd == 0) && (stage == 3'(k)) && busy;
                end
                start = 0;
                check("wait_hold", 32'(ok), 1);
            end
            if (k < 3) push_rd(k + 1);
            pulse_ack();
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 1);
        @(negedge clk);
        check("done_low", 32'(done), 0);
        check("busy_low", 32'(busy), 0);
        check("done_count", 32'(done_cnt - d0), 1);
        check("write_count", 32'(wr_seen - w0), 16);
        check("wr_q_empty", 32'(wr_q.size()), 0);
        check("rd_q_empty", 32'(rd_q.size()), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1;
        start = 0;
        in_valid = 0;
        stage_ack = 0;
        Re_in = '0;
        Im_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1 rst = 0;
        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(0, 1);
        run_frame(0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
